// File: rtl/pit_pkg.sv
// Shared types and widths for the interval-timer bus controller.
package pit_pkg;

  localparam int unsigned NUM_CNT = 3;
  localparam int unsigned DW      = 8;
  localparam int unsigned CW      = 6;
  localparam int unsigned VW      = 16;

  localparam logic [1:0] ADDR_CTRL = 2'd3;

  typedef enum logic [1:0] {
    RW_LATCH = 2'b00,
    RW_LSB   = 2'b01,
    RW_MSB   = 2'b10,
    RW_WORD  = 2'b11
  } rw_t;

  typedef enum logic {
    P_LSB = 1'b0,
    P_MSB = 1'b1
  } byte_ptr_t;

  typedef struct packed {
    rw_t        rw;
    logic [2:0] mode;
    logic       bcd;
  } ctrl_word_t;

  function automatic byte_ptr_t flipPtr(byte_ptr_t p);
    return (p == P_LSB) ? P_MSB : P_LSB;
  endfunction

endpackage

// File: rtl/pit_bus_if.sv
// CPU-side bus of the interval timer: select, strobes, address and data.
interface pit_bus_if;
  import pit_pkg::*;

  logic          cs_n;
  logic          wr_n;
  logic          rd_n;
  logic [1:0]    addr;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;

  modport master (output cs_n, wr_n, rd_n, addr, din, input dout);
  modport slave  (input cs_n, wr_n, rd_n, addr, din, output dout);
endinterface

// File: rtl/pit_cnt_port.sv
// Per-counter bus state: control word, write/read byte pointers and count latch.
module pit_cnt_port
  import pit_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ctrlWr,
  input  logic          latchCmd,
  input  logic          dataWr,
  input  logic          dataRd,
  input  logic [CW-1:0] ctrlIn,
  input  logic [VW-1:0] cntVal,
  output ctrl_word_t    ctrlWord,
  output logic          ctrlLoad,
  output logic          cntWr,
  output logic          cntHi_c,
  output logic [DW-1:0] rdByte_c
);

  byte_ptr_t     wPtr;
  byte_ptr_t     rPtr;
  logic [VW-1:0] latchReg;
  logic          latchValid;
  logic [VW-1:0] src_c;
  logic          lastRd_c;

  // Read source and the byte the current mode/pointer selects.
  always_comb begin
    src_c    = latchValid ? latchReg : cntVal;
    cntHi_c  = (ctrlWord.rw == RW_MSB) || ((ctrlWord.rw == RW_WORD) && (wPtr == P_MSB));
    rdByte_c = '0;
    lastRd_c = 1'b0;
    case (ctrlWord.rw)
      RW_LSB: begin
        rdByte_c = src_c[DW-1:0];
        lastRd_c = 1'b1;
      end
      RW_MSB: begin
        rdByte_c = src_c[VW-1:DW];
        lastRd_c = 1'b1;
      end
      RW_WORD: begin
        rdByte_c = (rPtr == P_MSB) ? src_c[VW-1:DW] : src_c[DW-1:0];
        lastRd_c = (rPtr == P_MSB);
      end
      default: begin
        rdByte_c = '0;
        lastRd_c = 1'b0;
      end
    endcase
  end

  // At most one decoded action reaches a port per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrlWord   <= '0;
      ctrlLoad   <= 1'b0;
      cntWr      <= 1'b0;
      wPtr       <= P_LSB;
      rPtr       <= P_LSB;
      latchReg   <= '0;
      latchValid <= 1'b0;
    end else begin
      ctrlLoad <= 1'b0;
      cntWr    <= 1'b0;
      if (ctrlWr) begin
        ctrlWord   <= ctrl_word_t'(ctrlIn);
        ctrlLoad   <= 1'b1;
        wPtr       <= P_LSB;
        rPtr       <= P_LSB;
        latchValid <= 1'b0;
      end else if (latchCmd) begin
        if (!latchValid) begin
          latchReg   <= cntVal;
          latchValid <= 1'b1;
        end
      end else if (dataWr) begin
        if (ctrlWord.rw != RW_LATCH) cntWr <= 1'b1;
        if (ctrlWord.rw == RW_WORD) wPtr <= flipPtr(wPtr);
      end else if (dataRd) begin
        if (ctrlWord.rw == RW_WORD) rPtr <= flipPtr(rPtr);
        if (lastRd_c) latchValid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pit_bus_ctrl.sv
// Bus-side read/write controller for the three-counter interval timer:
// strobe edge detect, address decode, per-counter ports and read-data register.
module pit_bus_ctrl
  import pit_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  pit_bus_if.slave               bus,
  output logic [NUM_CNT*CW-1:0]  ctrl_word,
  output logic [NUM_CNT-1:0]     ctrl_load,
  output logic [DW-1:0]          cnt_byte,
  output logic [NUM_CNT-1:0]     cnt_wr,
  output logic                   cnt_hi,
  input  logic [NUM_CNT*VW-1:0]  cnt_val
);

  logic               wrPrev;
  logic               rdPrev;
  logic               wrEdge_c;
  logic               rdEdge_c;
  logic               isCtrl_c;
  logic [NUM_CNT-1:0] ctrlSel_c;
  logic [NUM_CNT-1:0] latchSel_c;
  logic [NUM_CNT-1:0] wrSel_c;
  logic [NUM_CNT-1:0] rdSel_c;
  logic [NUM_CNT-1:0] hiArr_c;
  logic [DW-1:0]      rdArr_c [NUM_CNT];
  ctrl_word_t         cwArr   [NUM_CNT];
  logic [DW-1:0]      rdMux_c;
  logic               hiMux_c;

  // One action per falling strobe; a write on the same cycle masks the read.
  assign wrEdge_c = !bus.wr_n && wrPrev && !bus.cs_n;
  assign rdEdge_c = !bus.rd_n && rdPrev && !bus.cs_n && !wrEdge_c;
  assign isCtrl_c = (bus.addr == ADDR_CTRL);

  always_comb begin
    ctrlSel_c  = '0;
    latchSel_c = '0;
    wrSel_c    = '0;
    rdSel_c    = '0;
    rdMux_c    = '0;
    hiMux_c    = 1'b0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (wrEdge_c && isCtrl_c && (bus.din[7:6] == 2'(i))) begin
        if (bus.din[5:4] == RW_LATCH) latchSel_c[i] = 1'b1;
        else                          ctrlSel_c[i]  = 1'b1;
      end
      if (bus.addr == 2'(i)) begin
        wrSel_c[i] = wrEdge_c;
        rdSel_c[i] = rdEdge_c;
        rdMux_c    = rdArr_c[i];
        hiMux_c    = hiArr_c[i];
      end
    end
  end

  for (genvar i = 0; i < NUM_CNT; i++) begin : gPort
    pit_cnt_port uPort (
      .clk      (clk),
      .rst_n    (rst_n),
      .ctrlWr   (ctrlSel_c[i]),
      .latchCmd (latchSel_c[i]),
      .dataWr   (wrSel_c[i]),
      .dataRd   (rdSel_c[i]),
      .ctrlIn   (bus.din[CW-1:0]),
      .cntVal   (cnt_val[i*VW +: VW]),
      .ctrlWord (cwArr[i]),
      .ctrlLoad (ctrl_load[i]),
      .cntWr    (cnt_wr[i]),
      .cntHi_c  (hiArr_c[i]),
      .rdByte_c (rdArr_c[i])
    );
    assign ctrl_word[i*CW +: CW] = cwArr[i];
  end

  // Strobe history, shared count byte/qualifier and registered read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPrev   <= 1'b1;
      rdPrev   <= 1'b1;
      bus.dout <= '0;
      cnt_byte <= '0;
      cnt_hi   <= 1'b0;
    end else begin
      wrPrev <= bus.wr_n;
      rdPrev <= bus.rd_n;
      if (|wrSel_c) begin
        cnt_byte <= bus.din;
        cnt_hi   <= hiMux_c;
      end
      if (rdEdge_c) bus.dout <= isCtrl_c ? '0 : rdMux_c;
    end
  end

endmodule

// File: tb/tb_pit_bus_ctrl.sv
// Self-checking bench for pit_bus_ctrl: directed table, corner sequences, random vs model.
module tb_pit_bus_ctrl;
  import pit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [17:0] ctrl_word;
  logic [2:0]  ctrl_load;
  logic [7:0]  cnt_byte;
  logic [2:0]  cnt_wr;
  logic        cnt_hi;
  logic [47:0] cnt_val;

  always #5 clk = ~clk;

  pit_bus_if bus ();

  pit_bus_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .ctrl_word (ctrl_word),
    .ctrl_load (ctrl_load),
    .cnt_byte  (cnt_byte),
    .cnt_wr    (cnt_wr),
    .cnt_hi    (cnt_hi),
    .cnt_val   (cnt_val)
  );

  int checks = 0;
  int errors = 0;

  logic [2:0]  cWr, cLoad, aWr, aLoad;
  logic        cHi;
  logic [7:0]  cByte, cDout;
  logic [17:0] cCw;

  typedef struct {
    bit         isWr;
    logic [1:0] a;
    logic [7:0] d;
    logic [2:0] eWr;
    logic       eHi;
    logic [7:0] eByte;
    logic [2:0] eLoad;
    logic [7:0] eDout;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic idleBus();
    bus.cs_n = 1'b1;
    bus.wr_n = 1'b1;
    bus.rd_n = 1'b1;
    bus.addr = 2'd0;
    bus.din  = 8'h00;
  endtask

  // One strobe: capture right after the acting edge and one cycle later.
  task automatic busOp(input bit isWr, input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.cs_n = 1'b0;
    bus.addr = a;
    bus.din  = d;
    if (isWr) bus.wr_n = 1'b0;
    else      bus.rd_n = 1'b0;
    @(posedge clk); #1;
    cWr = cnt_wr; cLoad = ctrl_load; cHi = cnt_hi; cByte = cnt_byte;
    cDout = bus.dout; cCw = ctrl_word;
    @(negedge clk);
    idleBus();
    @(posedge clk); #1;
    aWr = cnt_wr; aLoad = ctrl_load;
  endtask

  task automatic checkAllZero(input string tag);
    chk({tag, "_dout"},  32'(bus.dout),  32'h0);
    chk({tag, "_cw"},    32'(ctrl_word), 32'h0);
    chk({tag, "_load"},  32'(ctrl_load), 32'h0);
    chk({tag, "_wr"},    32'(cnt_wr),    32'h0);
    chk({tag, "_hi"},    32'(cnt_hi),    32'h0);
    chk({tag, "_byte"},  32'(cnt_byte),  32'h0);
  endtask

  task automatic doReset();
    @(negedge clk);
    idleBus();
    rst_n = 1'b0;
    #2;
    checkAllZero("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic runTable();
    vec_t tbl [17];
    tbl[0]  = '{1, 2'd3, 8'h30, 3'b000, 0, 8'h00, 3'b001, 8'h00};
    tbl[1]  = '{1, 2'd0, 8'h34, 3'b001, 0, 8'h34, 3'b000, 8'h00};
    tbl[2]  = '{1, 2'd0, 8'h12, 3'b001, 1, 8'h12, 3'b000, 8'h00};
    tbl[3]  = '{1, 2'd3, 8'hA0, 3'b000, 0, 8'h00, 3'b100, 8'h00};
    tbl[4]  = '{1, 2'd2, 8'h55, 3'b100, 1, 8'h55, 3'b000, 8'h00};
    tbl[5]  = '{0, 2'd2, 8'h00, 3'b000, 0, 8'h00, 3'b000, 8'h5A};
    tbl[6]  = '{1, 2'd3, 8'h70, 3'b000, 0, 8'h00, 3'b010, 8'h5A};
    tbl[7]  = '{0, 2'd1, 8'h00, 3'b000, 0, 8'h00, 3'b000, 8'hCD};
    tbl[8]  = '{0, 2'd1, 8'h00, 3'b000, 0, 8'h00, 3'b000, 8'hAB};
    tbl[9]  = '{0, 2'd1, 8'h00, 3'b000, 0, 8'h00, 3'b000, 8'hCD};
    tbl[10] = '{0, 2'd3, 8'h00, 3'b000, 0, 8'h00, 3'b000, 8'h00};
    tbl[11] = '{1, 2'd3, 8'hD0, 3'b000, 0, 8'h00, 3'b000, 8'h00};
    tbl[12] = '{1, 2'd1, 8'h77, 3'b010, 0, 8'h77, 3'b000, 8'h00};
    tbl[13] = '{1, 2'd3, 8'h70, 3'b000, 0, 8'h00, 3'b010, 8'h00};
    tbl[14] = '{1, 2'd1, 8'h88, 3'b010, 0, 8'h88, 3'b000, 8'h00};
    tbl[15] = '{0, 2'd0, 8'h00, 3'b000, 0, 8'h00, 3'b000, 8'h34};
    tbl[16] = '{0, 2'd0, 8'h00, 3'b000, 0, 8'h00, 3'b000, 8'h12};
    cnt_val = {16'h5A3C, 16'hABCD, 16'h1234};
    for (int i = 0; i < 17; i++) begin
      busOp(tbl[i].isWr, tbl[i].a, tbl[i].d);
      chk($sformatf("tbl%0d_wr", i),   32'(cWr),   32'(tbl[i].eWr));
      chk($sformatf("tbl%0d_load", i), 32'(cLoad), 32'(tbl[i].eLoad));
      chk($sformatf("tbl%0d_dout", i), 32'(cDout), 32'(tbl[i].eDout));
      if (tbl[i].eWr != 3'b000) begin
        chk($sformatf("tbl%0d_hi", i),   32'(cHi),   32'(tbl[i].eHi));
        chk($sformatf("tbl%0d_byte", i), 32'(cByte), 32'(tbl[i].eByte));
      end
    end
  endtask

  // Reference model: per-counter mode, byte-order flags and latch, updated per access.
  task automatic runRandom(input int nOps);
    logic [5:0]  mCw  [3];
    bit          mWHi [3];
    bit          mRHi [3];
    bit          mLv  [3];
    logic [15:0] mLat [3];
    logic [7:0]  mDout;
    for (int k = 0; k < 3; k++) begin
      mCw[k] = '0; mWHi[k] = 0; mRHi[k] = 0; mLv[k] = 0; mLat[k] = '0;
    end
    mDout = 8'h00;
    for (int n = 0; n < nOps; n++) begin
      bit         isWr;
      int         a, sc, rw;
      logic [7:0] d;
      logic [2:0] eWr, eLoad;
      logic       eHi;
      logic [15:0] src;
      isWr = bit'($urandom_range(0, 1));
      a    = int'($urandom_range(0, 3));
      d    = 8'($urandom);
      cnt_val = {16'($urandom), 16'($urandom), 16'($urandom)};
      eWr = 3'b000; eLoad = 3'b000; eHi = 1'b0;
      if (isWr) begin
        if (a == 3) begin
          sc = int'(d[7:6]);
          if (sc != 3) begin
            if (d[5:4] == 2'b00) begin
              if (!mLv[sc]) begin
                mLat[sc] = cnt_val[sc*16 +: 16];
                mLv[sc]  = 1;
              end
            end else begin
              mCw[sc] = d[5:0]; mWHi[sc] = 0; mRHi[sc] = 0; mLv[sc] = 0;
              eLoad[sc] = 1'b1;
            end
          end
        end else begin
          rw = int'(mCw[a][5:4]);
          if (rw != 0) begin
            eWr[a] = 1'b1;
            eHi = (rw == 2) || (rw == 3 && mWHi[a]);
            if (rw == 3) mWHi[a] = !mWHi[a];
          end
        end
      end else begin
        if (a == 3) mDout = 8'h00;
        else begin
          src = mLv[a] ? mLat[a] : cnt_val[a*16 +: 16];
          rw  = int'(mCw[a][5:4]);
          case (rw)
            1: begin mDout = src[7:0];  mLv[a] = 0; end
            2: begin mDout = src[15:8]; mLv[a] = 0; end
            3: begin
              mDout = mRHi[a] ? src[15:8] : src[7:0];
              if (mRHi[a]) mLv[a] = 0;
              mRHi[a] = !mRHi[a];
            end
            default: mDout = 8'h00;
          endcase
        end
      end
      busOp(isWr, 2'(a), d);
      chk($sformatf("rnd%0d_wr", n),    32'(cWr),   32'(eWr));
      chk($sformatf("rnd%0d_load", n),  32'(cLoad), 32'(eLoad));
      chk($sformatf("rnd%0d_dout", n),  32'(cDout), 32'(mDout));
      chk($sformatf("rnd%0d_cw", n),    32'(cCw),   32'({mCw[2], mCw[1], mCw[0]}));
      chk($sformatf("rnd%0d_pulse", n), 32'({aWr, aLoad}), 32'h0);
      if (eWr != 3'b000) begin
        chk($sformatf("rnd%0d_hi", n),   32'(cHi),   32'(eHi));
        chk($sformatf("rnd%0d_byte", n), 32'(cByte), 32'(d));
      end
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    cnt_val = '0;
    idleBus();
    repeat (2) @(posedge clk);
    doReset();

    // Simultaneous strobes: write wins, dout keeps its old value.
    cnt_val = {16'h0, 16'h0, 16'h1234};
    busOp(1, 2'd3, 8'h10);
    chk("sim_ctrl_load", 32'(cLoad), 32'h1);
    busOp(0, 2'd0, 8'h00);
    chk("sim_pre_dout", 32'(cDout), 32'h34);
    cnt_val = {16'h0, 16'h0, 16'h00EE};
    @(negedge clk);
    bus.cs_n = 1'b0; bus.addr = 2'd0; bus.din = 8'h99;
    bus.wr_n = 1'b0; bus.rd_n = 1'b0;
    @(posedge clk); #1;
    chk("sim_wr",   32'(cnt_wr),   32'h1);
    chk("sim_byte", 32'(cnt_byte), 32'h99);
    chk("sim_hi",   32'(cnt_hi),   32'h0);
    chk("sim_dout", 32'(bus.dout), 32'h34);
    // Strobe held low: no second action.
    @(posedge clk); #1;
    chk("hold_wr",   32'(cnt_wr),   32'h0);
    chk("hold_dout", 32'(bus.dout), 32'h34);
    @(negedge clk);
    idleBus();
    @(posedge clk);

    // Reset in the middle of a word sequence.
    busOp(1, 2'd3, 8'h70);
    chk("rm_load", 32'(cLoad), 32'h2);
    @(negedge clk);
    bus.cs_n = 1'b0; bus.addr = 2'd1; bus.din = 8'h11; bus.wr_n = 1'b0;
    @(posedge clk); #1;
    chk("rm_lsb_wr", 32'(cnt_wr), 32'h2);
    rst_n = 1'b0;
    #1;
    checkAllZero("rm");
    @(negedge clk);
    idleBus();
    @(negedge clk);
    rst_n = 1'b1;
    busOp(1, 2'd1, 8'h22);
    chk("rm_after_wr", 32'(cWr), 32'h0);

    runTable();

    // Latch: snapshot held against live changes, second latch ignored.
    cnt_val = {16'h0, 16'hABCD, 16'h0};
    busOp(1, 2'd3, 8'h70);
    busOp(1, 2'd3, 8'h40);
    chk("lat_noload", 32'(cLoad), 32'h0);
    cnt_val = {16'h0, 16'h0001, 16'h0};
    busOp(1, 2'd3, 8'h40);
    busOp(0, 2'd1, 8'h00);
    chk("lat_lo", 32'(cDout), 32'hCD);
    busOp(0, 2'd1, 8'h00);
    chk("lat_hi", 32'(cDout), 32'hAB);
    busOp(0, 2'd1, 8'h00);
    chk("lat_live", 32'(cDout), 32'h01);

    doReset();
    runRandom(400);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
